// File: rtl/jt12_mod_sched_pkg.sv
// Shared slot op codes, algorithm encodings and record types for the FM modulation scheduler.
package jt12_mod_sched_pkg;

  typedef enum logic [1:0] {
    OP_S1 = 2'd0,
    OP_S2 = 2'd1,
    OP_S3 = 2'd2,
    OP_S4 = 2'd3
  } op_e;

  localparam logic [2:0] ALG0 = 3'd0;
  localparam logic [2:0] ALG1 = 3'd1;
  localparam logic [2:0] ALG2 = 3'd2;
  localparam logic [2:0] ALG3 = 3'd3;
  localparam logic [2:0] ALG4 = 3'd4;
  localparam logic [2:0] ALG5 = 3'd5;
  localparam logic [2:0] ALG6 = 3'd6;

  // S1 feedback shift is FB_SHIFT_BASE - fb, so fb=7 halves the two-sample sum twice.
  localparam int FB_SHIFT_BASE = 9;
  localparam int MAX_CH        = 8;

  typedef struct packed {
    logic       vld;
    logic [2:0] ch;
    op_e        op;
  } tag_t;

  typedef struct packed {
    logic d1;
    logic d2;
    logic v2;
    logic v3;
    logic fb_en;
  } src_sel_t;

  function automatic logic [3:0] op_onehot(input op_e op);
    return 4'b0001 << op;
  endfunction

endpackage

// File: rtl/jt12_mod_sched_if.sv
// Config, write-back and issued-slot bus between the modulation scheduler and the operator pipeline.
interface jt12_mod_sched_if #(
  parameter int OPW = 14
);
  logic                  cfg_we;
  logic [2:0]            cfg_ch;
  logic [2:0]            cfg_alg;
  logic [2:0]            cfg_fb;
  logic signed [OPW-1:0] op_result;

  logic                  s1_enters;
  logic                  s2_enters;
  logic                  s3_enters;
  logic                  s4_enters;
  logic [2:0]            slot_ch;
  logic [2:0]            alg_I;
  logic signed [OPW:0]   mod_out;
  logic                  slot_valid;
  logic                  sync;

  modport master (
    input  cfg_we, cfg_ch, cfg_alg, cfg_fb, op_result,
    output s1_enters, s2_enters, s3_enters, s4_enters,
    output slot_ch, alg_I, mod_out, slot_valid, sync
  );

  modport slave (
    output cfg_we, cfg_ch, cfg_alg, cfg_fb, op_result,
    input  s1_enters, s2_enters, s3_enters, s4_enters,
    input  slot_ch, alg_I, mod_out, slot_valid, sync
  );
endinterface

// File: rtl/jt12_mod_sched_route.sv
// Combinational (alg, op) -> modulation source selects; zero latency, no flow control.
module jt12_mod_sched_route
  import jt12_mod_sched_pkg::*;
(
  input  logic [2:0] alg_i,
  input  op_e        op_i,
  output src_sel_t   sel_o
);

  always_comb begin
    sel_o = '0;
    case (op_i)
      OP_S1: begin
        sel_o.d1    = 1'b1;
        sel_o.d2    = 1'b1;
        sel_o.fb_en = 1'b1;
      end
      OP_S2: begin
        sel_o.d1 = (alg_i == ALG0) || (alg_i == ALG3) || (alg_i == ALG4) ||
                   (alg_i == ALG5) || (alg_i == ALG6);
      end
      OP_S3: begin
        case (alg_i)
          ALG0:    sel_o.v2 = 1'b1;
          ALG1:    begin sel_o.d1 = 1'b1; sel_o.v2 = 1'b1; end
          ALG2:    sel_o.v2 = 1'b1;
          ALG5:    sel_o.d1 = 1'b1;
          default: ;
        endcase
      end
      OP_S4: begin
        case (alg_i)
          ALG0, ALG1, ALG4: sel_o.v3 = 1'b1;
          ALG2:    begin sel_o.d1 = 1'b1; sel_o.v3 = 1'b1; end
          ALG3:    begin sel_o.v2 = 1'b1; sel_o.v3 = 1'b1; end
          ALG5:    sel_o.d1 = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jt12_mod_sched.sv
// Op-major slot scheduler with per-channel config and operand store; outputs registered, one slot per clk_en.
// Results return RES_LAT advances after issue through a tag pipe; no stall path, clk_en is the only pacing.
module jt12_mod_sched
  import jt12_mod_sched_pkg::*;
#(
  parameter int num_ch  = 6,
  parameter int OPW     = 14,
  parameter int RES_LAT = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              clk_en,
  jt12_mod_sched_if.master bus
);

  logic [2:0]            ch_q, ch_d;
  op_e                   op_q, op_d;
  logic [2:0]            alg_ram_q [MAX_CH];
  logic [2:0]            fb_ram_q  [MAX_CH];
  logic signed [OPW-1:0] d1_q [MAX_CH];
  logic signed [OPW-1:0] d2_q [MAX_CH];
  logic signed [OPW-1:0] v2_q [MAX_CH];
  logic signed [OPW-1:0] v3_q [MAX_CH];
  tag_t                  tag_q [RES_LAT];

  logic [3:0]            enters_q;
  logic [2:0]            slot_ch_q;
  logic [2:0]            alg_out_q;
  logic signed [OPW:0]   mod_q, mod_d;
  logic                  slot_valid_q;
  logic                  sync_q;

  logic [2:0]            alg_cur;
  logic [2:0]            fb_cur;
  src_sel_t              sel;
  logic signed [OPW:0]   src_d1, src_d2, src_v2, src_v3, sum_w;
  logic [3:0]            shamt;
  tag_t                  wb_tag;

  assign alg_cur = alg_ram_q[ch_q];
  assign fb_cur  = fb_ram_q[ch_q];
  assign wb_tag  = tag_q[RES_LAT-1];

  jt12_mod_sched_route u_route (
    .alg_i (alg_cur),
    .op_i  (op_q),
    .sel_o (sel)
  );

  // ch_q/op_q name the slot the next clk_en will issue.
  always_comb begin
    ch_d = ch_q + 3'd1;
    op_d = op_q;
    if (ch_q == 3'(num_ch - 1)) begin
      ch_d = 3'd0;
      op_d = op_e'(op_q + 2'd1);
    end
  end

  always_comb begin
    src_d1 = '0;
    src_d2 = '0;
    src_v2 = '0;
    src_v3 = '0;
    if (sel.d1) src_d1 = {d1_q[ch_q][OPW-1], d1_q[ch_q]};
    if (sel.d2) src_d2 = {d2_q[ch_q][OPW-1], d2_q[ch_q]};
    if (sel.v2) src_v2 = {v2_q[ch_q][OPW-1], v2_q[ch_q]};
    if (sel.v3) src_v3 = {v3_q[ch_q][OPW-1], v3_q[ch_q]};
    sum_w = src_d1 + src_d2 + src_v2 + src_v3;
    shamt = 4'(FB_SHIFT_BASE) - {1'b0, fb_cur};
    mod_d = sum_w;
    if (sel.fb_en) begin
      if (fb_cur == 3'd0) mod_d = '0;
      else                mod_d = sum_w >>> shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q         <= '0;
      op_q         <= OP_S1;
      enters_q     <= '0;
      slot_ch_q    <= '0;
      alg_out_q    <= '0;
      mod_q        <= '0;
      slot_valid_q <= 1'b0;
      sync_q       <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
        alg_ram_q[i] <= '0;
        fb_ram_q[i]  <= '0;
        d1_q[i]      <= '0;
        d2_q[i]      <= '0;
        v2_q[i]      <= '0;
        v3_q[i]      <= '0;
      end
      for (int i = 0; i < RES_LAT; i++) tag_q[i] <= '0;
    end else begin
      // Issue reads the pre-edge RAM/store, so same-edge writes land after the issue.
      if (bus.cfg_we && (bus.cfg_ch < 3'(num_ch))) begin
        alg_ram_q[bus.cfg_ch] <= bus.cfg_alg;
        fb_ram_q[bus.cfg_ch]  <= bus.cfg_fb;
      end
      if (clk_en) begin
        ch_q         <= ch_d;
        op_q         <= op_d;
        enters_q     <= op_onehot(op_q);
        slot_ch_q    <= ch_q;
        alg_out_q    <= alg_cur;
        mod_q        <= mod_d;
        slot_valid_q <= 1'b1;
        sync_q       <= (ch_q == 3'd0) && (op_q == OP_S1);
        tag_q[0]     <= '{vld: 1'b1, ch: ch_q, op: op_q};
        for (int i = 1; i < RES_LAT; i++) tag_q[i] <= tag_q[i-1];
        if (wb_tag.vld) begin
          case (wb_tag.op)
            OP_S1: begin
              d2_q[wb_tag.ch] <= d1_q[wb_tag.ch];
              d1_q[wb_tag.ch] <= bus.op_result;
            end
            OP_S2:   v2_q[wb_tag.ch] <= bus.op_result;
            OP_S3:   v3_q[wb_tag.ch] <= bus.op_result;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.s1_enters  = enters_q[0];
  assign bus.s2_enters  = enters_q[1];
  assign bus.s3_enters  = enters_q[2];
  assign bus.s4_enters  = enters_q[3];
  assign bus.slot_ch    = slot_ch_q;
  assign bus.alg_I      = alg_out_q;
  assign bus.mod_out    = mod_q;
  assign bus.slot_valid = slot_valid_q;
  assign bus.sync       = sync_q;

endmodule

// File: tb/tb_jt12_mod_sched.sv
// Bench for jt12_mod_sched: slot-level reference model plus directed scenarios and a num_ch=3 instance.
module tb_jt12_mod_sched;

  localparam int N   = 6;
  localparam int L   = 4;
  localparam int OPW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic clk_en3 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  jt12_mod_sched_if #(.OPW(OPW)) bus ();
  jt12_mod_sched_if #(.OPW(OPW)) bus3 ();

  jt12_mod_sched #(.num_ch(N), .OPW(OPW), .RES_LAT(L)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus)
  );

  jt12_mod_sched #(.num_ch(3), .OPW(OPW), .RES_LAT(2)) dut3 (
    .clk(clk), .rst(rst), .clk_en(clk_en3), .bus(bus3)
  );

  always #5 clk = ~clk;

  // Reference model: slot number, per-channel config/store, queue of results in flight.
  typedef struct packed {
    int ch;
    int op;
    int due;
    int val;
  } pend_t;

  int    m_next, m_adv;
  int    m_alg [8];
  int    m_fb  [8];
  int    m_d1  [8];
  int    m_d2  [8];
  int    m_v2  [8];
  int    m_v3  [8];
  pend_t pq [$];
  int    force_val [8][4];
  bit    force_en  [8][4];
  int    e_op, e_ch, e_alg, e_mod, e_valid, e_sync;

  function automatic int ref_mod(input int ch, input int op);
    int a;
    a = m_alg[ch];
    if (op == 0) return (m_fb[ch] == 0) ? 0 : ((m_d1[ch] + m_d2[ch]) >>> (9 - m_fb[ch]));
    if (op == 1) return (a == 0 || a == 3 || a == 4 || a == 5 || a == 6) ? m_d1[ch] : 0;
    if (op == 2) begin
      if (a == 0 || a == 2) return m_v2[ch];
      if (a == 1) return m_d1[ch] + m_v2[ch];
      if (a == 5) return m_d1[ch];
      return 0;
    end
    if (a == 0 || a == 1 || a == 4) return m_v3[ch];
    if (a == 2) return m_d1[ch] + m_v3[ch];
    if (a == 3) return m_v2[ch] + m_v3[ch];
    if (a == 5) return m_d1[ch];
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_alg[i] = 0; m_fb[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_v2[i] = 0; m_v3[i] = 0;
    end
    pq.delete();
    m_next = 0; m_adv = 0;
    e_op = -1; e_ch = 0; e_alg = 0; e_mod = 0; e_valid = 0; e_sync = 0;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("s1_enters",  bus.s1_enters,  e_op == 0);
    chk("s2_enters",  bus.s2_enters,  e_op == 1);
    chk("s3_enters",  bus.s3_enters,  e_op == 2);
    chk("s4_enters",  bus.s4_enters,  e_op == 3);
    chk("slot_ch",    bus.slot_ch,    e_ch);
    chk("alg_I",      bus.alg_I,      e_alg);
    chk("mod_out",    bus.mod_out,    e_mod);
    chk("slot_valid", bus.slot_valid, e_valid);
    chk("sync",       bus.sync,       e_sync);
  endtask

  task automatic tick(input bit en);
    int ch, op, val, c, v;
    clk_en = en;
    if (en && pq.size() > 0 && pq[0].due == m_adv + 1) bus.op_result = OPW'(pq[0].val);
    else bus.op_result = OPW'($urandom);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (en) begin
        m_adv++;
        ch = m_next % N;
        op = m_next / N;
        e_op = op; e_ch = ch; e_alg = m_alg[ch]; e_mod = ref_mod(ch, op);
        e_valid = 1; e_sync = (m_next == 0);
        m_next = (m_next + 1) % (4 * N);
        if (pq.size() > 0 && pq[0].due == m_adv) begin
          c = pq[0].ch; v = pq[0].val;
          if (pq[0].op == 0) begin m_d2[c] = m_d1[c]; m_d1[c] = v; end
          else if (pq[0].op == 1) m_v2[c] = v;
          else if (pq[0].op == 2) m_v3[c] = v;
          void'(pq.pop_front());
        end
        val = force_en[ch][op] ? force_val[ch][op] : int'($urandom_range(16383)) - 8192;
        pq.push_back('{ch, op, m_adv + L, val});
      end
      if (bus.cfg_we && bus.cfg_ch < N) begin
        m_alg[bus.cfg_ch] = int'(bus.cfg_alg);
        m_fb[bus.cfg_ch]  = int'(bus.cfg_fb);
      end
    end
    #1;
    bus.cfg_we = 1'b0;
    check_outputs();
  endtask

  task automatic cfg(input int ch, input int alg, input int fb);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 3'(ch);
    bus.cfg_alg = 3'(alg);
    bus.cfg_fb  = 3'(fb);
  endtask

  task automatic run_until(input int n);
    int guard;
    guard = 0;
    while (m_adv < n && guard < 1000) begin
      tick($urandom_range(3) != 0);
      guard++;
    end
  endtask

  task automatic set_force(input int ch, input int op, input int val);
    force_en[ch][op]  = 1'b1;
    force_val[ch][op] = val;
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_alg = '0; bus.cfg_fb = '0; bus.op_result = '0;
    bus3.cfg_we = 1'b0; bus3.cfg_ch = '0; bus3.cfg_alg = '0; bus3.cfg_fb = '0; bus3.op_result = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) begin force_en[i][j] = 1'b0; force_val[i][j] = 0; end
    model_reset();

    // Reset state, including a clk_en held during reset.
    rst = 1'b1;
    tick(0);
    tick(1);
    chk("rst_valid", bus.slot_valid, 0);
    chk("rst_mod",   bus.mod_out,    0);
    chk("rst_sync",  bus.sync,       0);
    chk("rst_s1",    bus.s1_enters,  0);
    rst = 1'b0;

    cfg(0, 2, 0); tick(0);
    cfg(4, 0, 7); tick(0);
    cfg(7, 5, 5); tick(0);
    set_force(0, 0, 100); set_force(0, 1, -30); set_force(0, 2, 50);
    set_force(2, 0, 100); set_force(4, 0, 100);

    // First frame: op-major order and wrap back to ch0 S1.
    for (int i = 1; i <= 25; i++) begin
      int k;
      k = (i - 1) % 24;
      tick(1);
      chk("seq_ch",   bus.slot_ch,   k % N);
      chk("seq_s1",   bus.s1_enters, k / N == 0);
      chk("seq_s2",   bus.s2_enters, k / N == 1);
      chk("seq_s3",   bus.s3_enters, k / N == 2);
      chk("seq_s4",   bus.s4_enters, k / N == 3);
      chk("seq_sync", bus.sync,      k == 0);
      if (i == 9)  chk("ch2_s2_mod", bus.mod_out, 100);
      if (i == 13) chk("ch0_s3_mod", bus.mod_out, -30);
      if (i == 19) chk("ch0_s4_mod", bus.mod_out, 150);
    end

    // Feedback: frame-3 ch4 S1 sees d1=200, d2=100.
    set_force(4, 0, 200);
    run_until(52);
    tick(1);
    chk("fb7_ch",  bus.slot_ch, 4);
    chk("fb7_mod", bus.mod_out, 75);
    cfg(4, 0, 0); tick(0);

    // Config write colliding with ch1 S2 issue.
    run_until(55);
    cfg(1, 7, 0);
    tick(1);
    chk("coll_ch",      bus.slot_ch,   1);
    chk("coll_s2",      bus.s2_enters, 1);
    chk("coll_alg_old", bus.alg_I,     0);
    run_until(61);
    tick(1);
    chk("alg7_s3_alg", bus.alg_I,     7);
    chk("alg7_s3",     bus.s3_enters, 1);
    chk("alg7_s3_mod", bus.mod_out,   0);
    run_until(67);
    tick(1);
    chk("alg7_s4_alg", bus.alg_I,   7);
    chk("alg7_s4_mod", bus.mod_out, 0);
    run_until(76);
    tick(1);
    chk("fb0_ch",  bus.slot_ch, 4);
    chk("fb0_mod", bus.mod_out, 0);

    // Randomized traffic: results, idle cycles and config writes (incl. out-of-range channels).
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) force_en[i][j] = 1'b0;
    set_force(0, 0, 1000);
    for (int i = 0; i < 220; i++) begin
      if ($urandom_range(3) == 0) cfg($urandom_range(7), $urandom_range(7), $urandom_range(7));
      tick($urandom_range(3) != 0);
    end

    // Mid-frame reset with results in flight.
    for (int i = 0; i < 5; i++) tick(1);
    rst = 1'b1;
    tick(1);
    chk("mrst_valid", bus.slot_valid, 0);
    chk("mrst_mod",   bus.mod_out,    0);
    chk("mrst_ch",    bus.slot_ch,    0);
    rst = 1'b0;
    cfg(0, 0, 7); tick(0);
    tick(1);
    chk("restart_sync", bus.sync,      1);
    chk("restart_s1",   bus.s1_enters, 1);
    chk("restart_ch",   bus.slot_ch,   0);
    chk("restart_mod",  bus.mod_out,   0);
    for (int i = 0; i < 40; i++) tick($urandom_range(3) != 0);

    // num_ch=3 instance: 12-slot frame, RES_LAT=2.
    clk_en = 1'b0;
    rst = 1'b1;
    tick(0);
    chk("n3_rst_valid", bus3.slot_valid, 0);
    rst = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      int k;
      k = (i - 1) % 12;
      bus3.op_result = (i == 4) ? 14'sd100 : 14'sd0;
      clk_en3 = 1'b1;
      @(posedge clk);
      #1;
      clk_en3 = 1'b0;
      chk("n3_ch",   bus3.slot_ch,   k % 3);
      chk("n3_s1",   bus3.s1_enters, k / 3 == 0);
      chk("n3_s2",   bus3.s2_enters, k / 3 == 1);
      chk("n3_s3",   bus3.s3_enters, k / 3 == 2);
      chk("n3_s4",   bus3.s4_enters, k / 3 == 3);
      chk("n3_sync", bus3.sync,      k == 0);
      if (i == 5) chk("n3_ch1_s2_mod", bus3.mod_out, 100);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
